des_f_sequencer: RTL and testbench



---
 rtl/des_f_sequencer_if.sv | 25 ++
 rtl/des_f_sequencer.sv | 126 ++++++++++++
 tb/tb_des_f_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_f_sequencer_if.sv
// Handshake, result and S-box ROM port bundle for the serial DES f-function engine.
// The slave side is the engine; the master side is its environment (round control plus ROM bank).
interface des_f_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] r_in;
   logic [47:0] k_in;
   logic [2:0]  sbox_sel;
   logic [5:0]  sbox_addr;
   logic [3:0]  sbox_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] f_out;
   logic        busy;

   modport slave (
      input  in_valid, r_in, k_in, sbox_data, out_ready,
      output in_ready, sbox_sel, sbox_addr, out_valid, f_out, busy
   );

   modport master (
      output in_valid, r_in, k_in, sbox_data, out_ready,
      input  in_ready, sbox_sel, sbox_addr, out_valid, f_out, busy
   );
endinterface

// File: rtl/des_f_sequencer.sv
// Serial DES round function: E(R)^K, eight sequential S-box lookups through one shared
// ROM port, then the P permutation. Vector bit 31/47 corresponds to DES bit 1.
module des_f_sequencer (
   input  logic             clk,
   input  logic             rst_n,
   des_f_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Expansion and permutation tables, 1-based DES bit numbers.
   localparam int E_TAB [48] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1
   };

   localparam int P_TAB [32] = '{
      16,  7, 20, 21,
      29, 12, 28, 17,
       1, 15, 23, 26,
       5, 18, 31, 10,
       2,  8, 24, 14,
      32, 27,  3,  9,
      19, 13, 30,  6,
      22, 11,  4, 25
   };

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [47:0] mix_q, mix_d;
   logic [31:0] cat_q, cat_d;
   logic [31:0] f_q, f_d;

   function automatic logic [47:0] e_expand(input logic [31:0] r);
      logic [47:0] e;
      e = '0;
      for (int i = 0; i < 48; i++) begin
         e[47-i] = r[32-E_TAB[i]];
      end
      return e;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] c);
      logic [31:0] p;
      p = '0;
      for (int i = 0; i < 32; i++) begin
         p[31-i] = c[32-P_TAB[i]];
      end
      return p;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mix_q   <= '0;
         cat_q   <= '0;
         f_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mix_q   <= mix_d;
         cat_q   <= cat_d;
         f_q     <= f_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mix_d   = mix_q;
      cat_d   = cat_q;
      f_d     = f_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mix_d   = e_expand(bus.r_in) ^ bus.k_in;
               cat_d   = '0;
               idx_d   = '0;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            cat_d[31 - 4*int'(idx_q) -: 4] = bus.sbox_data;
            // Incrementing past 7 wraps idx back to 0 as the engine leaves LOOKUP.
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               f_d     = p_perm(cat_d);
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ROM address is forced to zero outside LOOKUP so the shared port is quiet when idle.
   always_comb begin
      bus.sbox_sel  = '0;
      bus.sbox_addr = '0;
      if (state_q == LOOKUP) begin
         bus.sbox_sel  = idx_q;
         bus.sbox_addr = mix_q[47 - 6*int'(idx_q) -: 6];
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.f_out     = f_q;

endmodule

// File: tb/tb_des_f_sequencer.sv
// Directed bench for des_f_sequencer: driver pushes hand-computed expectations into a
// scoreboard queue, an independent negedge monitor checks ROM sequencing and results.
module tb_des_f_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rom_stub = 1'b0;

   des_f_sequencer_if bus();

   des_f_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] f;
      logic [47:0] mix;
   } exp_t;

   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   acc_cyc = 0;
   logic ov_prev = 1'b0;

   // S1..S8, each 4 rows of 16 columns.
   localparam int SB [512] = '{
      14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
      15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
      10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
       7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
       2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
      12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
       4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
      13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
   };

   // {sel, row(b1,b6), col(b2..b5)} is exactly sel*64 + row*16 + col.
   function automatic logic [3:0] rom(input logic [2:0] sel, input logic [5:0] a);
      return 4'(SB[int'({sel, a[5], a[0], a[4:1]})]);
   endfunction

   assign bus.sbox_data = rom_stub ? {1'b0, bus.sbox_sel} : rom(bus.sbox_sel, bus.sbox_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   task automatic send(input logic [31:0] r, input logic [47:0] k);
      int n;
      bus.r_in     = r;
      bus.k_in     = k;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) timeout("accept");
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.busy) timeout("wait_idle");
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Scoreboard monitor.
   initial begin
      int k;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
            if (bus.busy && !bus.out_valid) begin
               k = cyc - acc_cyc;
               if (exp_q.size() == 0) begin
                  timeout("lookup_without_transaction");
               end else begin
                  chk("sbox_sel", 64'(bus.sbox_sel), 64'(k));
                  if (k >= 0 && k < 8)
                     chk("sbox_addr", 64'(bus.sbox_addr), 64'(exp_q[0].mix[47 - 6*k -: 6]));
               end
            end
            if (bus.out_valid && !ov_prev) chk("latency", 64'(cyc - acc_cyc), 64'd8);
            if (bus.out_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: f_out %0h with no pending transaction", bus.f_out);
               end else begin
                  chk("f_out", 64'(bus.f_out), 64'(exp_q[0].f));
                  chk("done_busy", 64'(bus.busy), 64'd1);
                  if (bus.out_ready) void'(exp_q.pop_front());
                  else chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
               end
            end
         end
         ov_prev = bus.out_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int a1;
      int a2;
      bus.in_valid  = 1'b0;
      bus.r_in      = '0;
      bus.k_in      = '0;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy",      64'(bus.busy),      64'd0);
      chk("rst_sbox_sel",  64'(bus.sbox_sel),  64'd0);
      chk("rst_sbox_addr", 64'(bus.sbox_addr), 64'd0);
      chk("rst_f_out",     64'(bus.f_out),     64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known vector with the real ROM bank.
      exp_q.push_back('{f: 32'h234AA9BB, mix: 48'h6117BA866527});
      send(32'hF0AAF0AA, 48'h1B02EFFC7072);
      wait_idle();

      // All-zero inputs: cat = EFA72C4D.
      exp_q.push_back('{f: 32'hD8D8DBBC, mix: 48'h0});
      send(32'h0, 48'h0);
      wait_idle();

      // Stub ROM returning the select: cat = 01234567.
      rom_stub = 1'b1;
      exp_q.push_back('{f: 32'h80566C2C, mix: 48'h0});
      send(32'h0, 48'h0);
      wait_idle();
      rom_stub = 1'b0;

      // Back-pressure with in_valid pulsing while the result is held.
      bus.out_ready = 1'b0;
      exp_q.push_back('{f: 32'hD8D8DBBC, mix: 48'h0});
      send(32'h0, 48'h0);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.out_valid) timeout("bp_out_valid");
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         bus.in_valid = ~bus.in_valid;
         bus.r_in     = 32'hF0AAF0AA ^ 32'(i);
         bus.k_in     = 48'h1B02EFFC7072;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      chk("bp_release_busy",     64'(bus.busy),     64'd0);

      // Back-to-back with in_valid and out_ready held high.
      exp_q.push_back('{f: 32'h234AA9BB, mix: 48'h6117BA866527});
      exp_q.push_back('{f: 32'hD8D8DBBC, mix: 48'h0});
      bus.r_in     = 32'hF0AAF0AA;
      bus.k_in     = 48'h1B02EFFC7072;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      a1 = cyc;
      bus.r_in = 32'h0;
      bus.k_in = 48'h0;
      n = 0;
      while (!bus.in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) timeout("b2b_second_accept");
      @(posedge clk); #1;
      a2 = cyc;
      bus.in_valid = 1'b0;
      chk("b2b_interval", 64'(a2 - a1), 64'd10);
      wait_idle();

      // Reset in the middle of LOOKUP at idx = 3.
      exp_q.push_back('{f: 32'h234AA9BB, mix: 48'h6117BA866527});
      send(32'hF0AAF0AA, 48'h1B02EFFC7072);
      n = 0;
      while (bus.sbox_sel != 3'd3 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.sbox_sel != 3'd3) timeout("reach_idx3");
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("arst_busy",      64'(bus.busy),      64'd0);
      chk("arst_sbox_sel",  64'(bus.sbox_sel),  64'd0);
      chk("arst_sbox_addr", 64'(bus.sbox_addr), 64'd0);
      chk("arst_f_out",     64'(bus.f_out),     64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("post_rst_busy",      64'(bus.busy),      64'd0);
      chk("scoreboard_empty",   64'(exp_q.size()),  64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
